// File: rtl/serial_equality_controller.sv
// serial_equality_controller
//
// Compares two WIDTH-bit operands one bit at a time. The bit comparison
// itself is done by an external 1-bit equality comparator. The search
// starts at bit 0 and stops at the first differing bit.
//
// Ports:
//   clk         - system clock, rising-edge active
//   rst_n       - asynchronous active-low reset
//   start       - compare request, accepted only in IDLE
//   a, b        - operands, captured when start is accepted
//   cmp_a/cmp_b - bit pair driven to the external comparator (0 outside COMPARE)
//   cmp_eq      - combinational XNOR result returned by the comparator
//   busy        - high while in COMPARE
//   done        - one-cycle completion pulse (DONE state)
//   equal       - 1 when the operands were identical
//   mis_idx     - lowest differing bit position (0 when equal)
//   dbg_state_o - current FSM state, for observation only
//
// Handshake: start is a request with no ready signal. It is accepted on a
// rising edge only while the FSM is in IDLE. In COMPARE and DONE it is
// ignored and not queued. done pulses once per accepted request. equal and
// mis_idx stay valid from DONE until the next accepted start.
module serial_equality_controller #(
  parameter int WIDTH = 5,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDXW-1:0]  mis_idx,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic             equal_q, equal_d;
  logic [IDXW-1:0]  mis_idx_q, mis_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      equal_q   <= 1'b0;
      mis_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      equal_q   <= equal_d;
      mis_idx_q <= mis_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    equal_d   = equal_q;
    mis_idx_d = mis_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          k_d       = '0;
          equal_d   = 1'b0;
          mis_idx_d = '0;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        if (!cmp_eq) begin
          // First differing bit found: stop early.
          equal_d   = 1'b0;
          mis_idx_d = k_q;
          state_d   = DONE;
        end else if (k_q == LAST_IDX) begin
          equal_d   = 1'b1;
          mis_idx_d = '0;
          state_d   = DONE;
        end else begin
          k_d = k_q + IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The comparator outputs depend only on registers. This keeps the
  // external cmp_eq path free of combinational loops.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    cmp_a = 1'b0;
    cmp_b = 1'b0;
    if (state_q == COMPARE) begin
      busy  = 1'b1;
      cmp_a = a_q[k_q];
      cmp_b = b_q[k_q];
    end
    if (state_q == DONE) begin
      done = 1'b1;
    end
  end

  assign equal       = equal_q;
  assign mis_idx     = mis_idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_equality_controller.sv
// Testbench for serial_equality_controller (WIDTH=5).
// The external comparator is modelled as cmp_eq = ~(cmp_a ^ cmp_b).
// Expected results come from a reference model at the operand level:
// - the lowest set bit of a^b gives mis_idx and the done cycle;
// - when a == b, the result is equal=1 and done comes in cycle WIDTH+1.
module tb_serial_equality_controller;

  localparam int W    = 5;
  localparam int IDXW = 3;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            cmp_a;
  logic            cmp_b;
  logic            cmp_eq;
  logic            busy;
  logic            done;
  logic            equal;
  logic [IDXW-1:0] mis_idx;
  logic [1:0]      dbg_state;

  int unsigned n_vec;
  int unsigned n_err;

  serial_equality_controller #(.WIDTH(W), .IDXW(IDXW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_eq      (cmp_eq),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .mis_idx     (mis_idx),
    .dbg_state_o (dbg_state)
  );

  assign cmp_eq = ~(cmp_a ^ cmp_b);

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Idle cycles: nothing runs, and the last result is held.
  task automatic idle_hold(input int n, input logic e_eq, input logic [IDXW-1:0] e_idx);
    repeat (n) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("hold_equal", 32'(equal), 32'(e_eq));
      chk("hold_mis_idx", 32'(mis_idx), 32'(e_idx));
      @(posedge clk); #1;
    end
  endtask

  // Runs one comparison and checks it cycle by cycle against the model.
  // hold:     keep start high the whole time.
  // scramble: change the a/b inputs (and start when not held) during COMPARE.
  // On return, the bench is #1 after the edge that leaves DONE (IDLE cycle).
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold, input bit scramble);
    logic [W-1:0]    diff;
    int              j;
    int              exp_done;
    logic            exp_eq;
    logic [IDXW-1:0] exp_idx;
    logic            in_cmp;
    diff = av ^ bv;
    j = -1;
    for (int i = W - 1; i >= 0; i--) if (diff[i]) j = i;
    if (j < 0) begin
      exp_eq = 1'b1; exp_idx = '0; exp_done = W + 1;
    end else begin
      exp_eq = 1'b0; exp_idx = IDXW'(j); exp_done = j + 2;
    end

    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;                 // edge 0: start accepted
    if (!hold) start = 1'b0;
    chk("equal_cleared", 32'(equal), 0);
    chk("mis_idx_cleared", 32'(mis_idx), 0);

    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      in_cmp = (cyc < exp_done);
      chk("busy", 32'(busy), 32'(in_cmp));
      chk("done", 32'(done), 32'(!in_cmp));
      chk("cmp_a", 32'(cmp_a), in_cmp ? 32'(av[cyc-1]) : 0);
      chk("cmp_b", 32'(cmp_b), in_cmp ? 32'(bv[cyc-1]) : 0);
      if (!in_cmp) begin
        chk("result_equal", 32'(equal), 32'(exp_eq));
        chk("result_mis_idx", 32'(mis_idx), 32'(exp_idx));
        if (!hold) start = 1'b0;
      end else begin
        if (scramble) begin
          a = W'($urandom);
          b = W'($urandom);
          if (!hold) start = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;                 // back in IDLE
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_equal", 32'(equal), 32'(exp_eq));
    chk("post_mis_idx", 32'(mis_idx), 32'(exp_idx));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_vec = 0;
    n_err = 0;
    a = '0; b = '0; start = 1'b0; rst_n = 1'b0;

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_equal", 32'(equal), 0);
    chk("rst_mis_idx", 32'(mis_idx), 0);
    chk("rst_cmp_a", 32'(cmp_a), 0);
    chk("rst_cmp_b", 32'(cmp_b), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Mismatch at bit 0: done in cycle 2.
    run_cmp(5'b10101, 5'b01010, 1'b0, 1'b0);
    // Mismatch at bit 3: done in cycle 5.
    run_cmp(5'b00100, 5'b01100, 1'b0, 1'b0);
    // Identical operands: done in cycle 6.
    run_cmp(5'b10110, 5'b10110, 1'b0, 1'b0);
    idle_hold(2, 1'b1, '0);

    // start held high with the inputs scrambled. The captured values are
    // used, and a new request is accepted in the IDLE cycle after done.
    run_cmp(5'b11001, 5'b11001, 1'b1, 1'b1);
    run_cmp(5'b00110, 5'b10110, 1'b0, 1'b0);
    idle_hold(1, 1'b0, 3'd4);

    // Back-to-back requests; the first result holds until the second start.
    run_cmp(5'b00000, 5'b00000, 1'b0, 1'b0);
    idle_hold(3, 1'b1, '0);
    run_cmp(5'b00011, 5'b00001, 1'b0, 1'b0);
    idle_hold(2, 1'b0, 3'd1);

    // Reset in the middle of the cycle-3 comparison of 11111/11111.
    @(negedge clk);
    a = 5'b11111; b = 5'b11111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;   // cycle 1
    @(posedge clk); #1;                 // cycle 2
    @(posedge clk); #1;                 // cycle 3
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_equal", 32'(equal), 0);
    chk("async_rst_mis_idx", 32'(mis_idx), 0);
    chk("async_rst_cmp_a", 32'(cmp_a), 0);
    chk("async_rst_cmp_b", 32'(cmp_b), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_hold(8, 1'b0, '0);             // no done pulse after abort
    run_cmp(5'b11111, 5'b11111, 1'b0, 1'b0);

    // Random operands. Equal pairs and single-bit differences are biased in.
    repeat (30) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
